// File: rtl/spio_uart_rx_pkg.sv
// Shared UART definitions: receive FSM encodings and bit-timing constants.
`timescale 1ns/1ps
package spio_uart_rx_pkg;

   typedef logic [7:0] uart_byte_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   localparam int unsigned SUBSAMPLES_PER_BIT = 8;
   localparam int unsigned START_CENTRE       = 4;

   // Counter values seen on the pulse that lands on a bit centre.
   localparam logic [2:0] LAST_SUBSAMPLE   = 3'(SUBSAMPLES_PER_BIT - 1);
   localparam logic [2:0] START_CENTRE_CNT = 3'(START_CENTRE - 1);
   localparam logic [2:0] LAST_BIT         = 3'd7;

endpackage

// File: rtl/spio_uart_rx_if.sv
// Received-byte stream (valid/ready) plus the single-cycle error pulses.
`timescale 1ns/1ps
interface spio_uart_rx_if;
   import spio_uart_rx_pkg::*;

   uart_byte_t data;
   logic       vld;
   logic       rdy;
   logic       framing_error;
   logic       overrun;

   modport master (output data, vld, framing_error, overrun, input rdy);
   modport slave  (input data, vld, framing_error, overrun, output rdy);
endinterface

// File: rtl/spio_uart_sync.sv
// Metastability synchroniser for an asynchronous level; resets to 1 (idle line).
`timescale 1ns/1ps
module spio_uart_sync #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] stages;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stages <= '1;
      else     stages <= {stages[DEPTH-2:0], d};
   end

   assign q = stages[DEPTH-1];

endmodule

// File: rtl/spio_uart_rx.sv
// 8N1 UART receiver on an external 8x subsample strobe; one-entry output register,
// a byte arriving while the register is still full is dropped and flagged as overrun.
`timescale 1ns/1ps
module spio_uart_rx
   import spio_uart_rx_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             CLK_IN,
   input  logic             RESET_IN,
   input  logic             SUBSAMPLE_PULSE_IN,
   input  logic             RX_IN,
   spio_uart_rx_if.master   out_if
);

   logic       rx_s;
   rx_state_t  state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [2:0] idx, idx_nxt;
   uart_byte_t shreg, shreg_nxt;
   logic       stop_sample, byte_done, stop_low;

   uart_byte_t data_q;
   logic       vld_q, fe_q, ov_q;

   spio_uart_sync #(.DEPTH(SYNC_STAGES)) u_sync (
      .clk (CLK_IN),
      .rst (RESET_IN),
      .d   (RX_IN),
      .q   (rx_s)
   );

   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shreg <= shreg_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      if (SUBSAMPLE_PULSE_IN) begin
         case (state)
            IDLE: if (!rx_s) begin
               state_nxt = START;
               cnt_nxt   = '0;
            end
            START: begin
               cnt_nxt = cnt + 3'd1;
               if (cnt == START_CENTRE_CNT) begin
                  // A start bit that has gone high by its centre was a glitch.
                  cnt_nxt   = '0;
                  idx_nxt   = '0;
                  state_nxt = rx_s ? IDLE : DATA;
               end
            end
            DATA: begin
               cnt_nxt = cnt + 3'd1;
               if (cnt == LAST_SUBSAMPLE) begin
                  shreg_nxt = {rx_s, shreg[7:1]};
                  idx_nxt   = idx + 3'd1;
                  if (idx == LAST_BIT) begin
                     state_nxt = STOP;
                     cnt_nxt   = '0;
                  end
               end
            end
            STOP: begin
               cnt_nxt = cnt + 3'd1;
               if (cnt == LAST_SUBSAMPLE) begin
                  cnt_nxt   = '0;
                  state_nxt = rx_s ? IDLE : BREAK;
               end
            end
            BREAK: if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      stop_sample = SUBSAMPLE_PULSE_IN && (state == STOP) && (cnt == LAST_SUBSAMPLE);
      byte_done   = stop_sample && rx_s;
      stop_low    = stop_sample && !rx_s;
   end

   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         data_q <= '0;
         vld_q  <= 1'b0;
         fe_q   <= 1'b0;
         ov_q   <= 1'b0;
      end else begin
         fe_q <= stop_low;
         ov_q <= 1'b0;
         // A consume in the same cycle frees the register for the new byte.
         if (byte_done && (!vld_q || out_if.rdy)) begin
            data_q <= shreg;
            vld_q  <= 1'b1;
         end else begin
            if (byte_done)             ov_q  <= 1'b1;
            if (vld_q && out_if.rdy)   vld_q <= 1'b0;
         end
      end
   end

   assign out_if.data          = data_q;
   assign out_if.vld           = vld_q;
   assign out_if.framing_error = fe_q;
   assign out_if.overrun       = ov_q;

endmodule

// File: tb/tb_spio_uart_rx.sv
// Directed bench: frames aligned to the subsample strobe so completion edges are exact.
`timescale 1ns/1ps
module tb_spio_uart_rx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic [1:0] div = 2'd0;
   logic sub_pulse;

   spio_uart_rx_if rx_if ();

   spio_uart_rx #(.SYNC_STAGES(2)) dut (
      .CLK_IN             (clk),
      .RESET_IN           (rst),
      .SUBSAMPLE_PULSE_IN (sub_pulse),
      .RX_IN              (rx),
      .out_if             (rx_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) div <= div + 2'd1;
   assign sub_pulse = (div == 2'd3);

   // Output monitor, sampled mid-cycle.
   int acc_n = 0, rise_n = 0, fe_n = 0, ov_n = 0, fe_long = 0, ov_long = 0;
   logic [7:0] acc_last = 8'h00;
   logic vld_p = 1'b0, fe_p = 1'b0, ov_p = 1'b0;

   always @(negedge clk) begin
      if (rx_if.vld && rx_if.rdy) begin
         acc_n++;
         acc_last = rx_if.data;
      end
      if (rx_if.vld && !vld_p) rise_n++;
      if (rx_if.framing_error) begin
         fe_n++;
         if (fe_p) fe_long++;
      end
      if (rx_if.overrun) begin
         ov_n++;
         if (ov_p) ov_long++;
      end
      vld_p = rx_if.vld;
      fe_p  = rx_if.framing_error;
      ov_p  = rx_if.overrun;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns just after a posedge on which the strobe is high.
   task automatic align();
      @(negedge clk);
      while (!sub_pulse) @(negedge clk);
      @(posedge clk);
   endtask

   // Start bit driven 1ns after the aligned edge P0; stop bit is sampled at P308.
   task automatic send_bits(input logic [7:0] b, input logic stop);
      #1 rx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (32) @(posedge clk);
         #1 rx = b[i];
      end
      repeat (32) @(posedge clk);
      #1 rx = stop;
      repeat (32) @(posedge clk);
   endtask

   int b_acc, b_rise, b_fe, b_ov;

   task automatic snap();
      b_acc = acc_n; b_rise = rise_n; b_fe = fe_n; b_ov = ov_n;
   endtask

   initial begin
      rx_if.rdy = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_data", 32'(rx_if.data), 32'h00);
      check("rst_vld",  32'(rx_if.vld), 32'd0);
      check("rst_fe",   32'(rx_if.framing_error), 32'd0);
      check("rst_ov",   32'(rx_if.overrun), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (64) @(posedge clk);

      // 8'hA5, consumer always ready: one-cycle latency, one-cycle valid
      snap();
      align();
      fork
         send_bits(8'hA5, 1'b1);
         begin
            repeat (307) @(posedge clk);
            @(negedge clk);
            check("a5_vld_before", 32'(rx_if.vld), 32'd0);
            @(negedge clk);
            check("a5_vld", 32'(rx_if.vld), 32'd1);
            check("a5_data", 32'(rx_if.data), 32'hA5);
            @(negedge clk);
            check("a5_vld_after", 32'(rx_if.vld), 32'd0);
         end
      join
      repeat (64) @(posedge clk);
      check("a5_acc_n", 32'(acc_n - b_acc), 32'd1);
      check("a5_rise_n", 32'(rise_n - b_rise), 32'd1);
      check("a5_fe_n", 32'(fe_n - b_fe), 32'd0);
      check("a5_ov_n", 32'(ov_n - b_ov), 32'd0);

      // Two-subsample low glitch on an idle line
      snap();
      align();
      #1 rx = 1'b0;
      repeat (8) @(posedge clk);
      #1 rx = 1'b1;
      repeat (400) @(posedge clk);
      @(negedge clk);
      check("glitch_vld", 32'(rx_if.vld), 32'd0);
      check("glitch_rise_n", 32'(rise_n - b_rise), 32'd0);
      check("glitch_fe_n", 32'(fe_n - b_fe), 32'd0);
      check("glitch_ov_n", 32'(ov_n - b_ov), 32'd0);

      // 8'h3C with a low stop bit, then line held low for 20 bit-times
      snap();
      align();
      send_bits(8'h3C, 1'b0);
      repeat (640) @(posedge clk);
      check("brk_fe_n", 32'(fe_n - b_fe), 32'd1);
      check("brk_fe_long", 32'(fe_long), 32'd0);
      check("brk_rise_n", 32'(rise_n - b_rise), 32'd0);
      #1 rx = 1'b1;
      repeat (64) @(posedge clk);
      check("brk_idle_fe_n", 32'(fe_n - b_fe), 32'd1);
      check("brk_idle_rise_n", 32'(rise_n - b_rise), 32'd0);
      align();
      send_bits(8'h81, 1'b1);
      repeat (32) @(posedge clk);
      check("brk_recover_acc_n", 32'(acc_n - b_acc), 32'd1);
      check("brk_recover_data", 32'(acc_last), 32'h81);

      // Overrun: 8'h11 then 8'h22 with the consumer stalled
      snap();
      rx_if.rdy = 1'b0;
      align();
      send_bits(8'h11, 1'b1);
      align();
      send_bits(8'h22, 1'b1);
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("ovr_vld", 32'(rx_if.vld), 32'd1);
      check("ovr_data", 32'(rx_if.data), 32'h11);
      check("ovr_ov_n", 32'(ov_n - b_ov), 32'd1);
      check("ovr_ov_long", 32'(ov_long), 32'd0);
      check("ovr_fe_n", 32'(fe_n - b_fe), 32'd0);
      @(posedge clk); #1 rx_if.rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ovr_drain_vld", 32'(rx_if.vld), 32'd0);
      check("ovr_drain_data", 32'(rx_if.data), 32'h11);
      check("ovr_drain_acc", 32'(acc_last), 32'h11);

      // Byte completes on the same edge the pending byte is consumed
      snap();
      rx_if.rdy = 1'b0;
      align();
      send_bits(8'h01, 1'b1);
      align();
      fork
         send_bits(8'h02, 1'b1);
         begin
            repeat (307) @(posedge clk);
            #1 rx_if.rdy = 1'b1;
            @(posedge clk);
            #1 rx_if.rdy = 1'b0;
            @(negedge clk);
            check("same_vld", 32'(rx_if.vld), 32'd1);
            check("same_data", 32'(rx_if.data), 32'h02);
            check("same_acc", 32'(acc_last), 32'h01);
         end
      join
      repeat (8) @(posedge clk);
      check("same_ov_n", 32'(ov_n - b_ov), 32'd0);
      check("same_rise_n", 32'(rise_n - b_rise), 32'd1);

      // Reset during bit 4 of 8'hFF while a byte is still pending
      align();
      #1 rx = 1'b0;
      repeat (32) @(posedge clk);
      #1 rx = 1'b1;
      repeat (144) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_data", 32'(rx_if.data), 32'h00);
      check("mid_rst_vld", 32'(rx_if.vld), 32'd0);
      check("mid_rst_fe", 32'(rx_if.framing_error), 32'd0);
      check("mid_rst_ov", 32'(rx_if.overrun), 32'd0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      repeat (64) @(posedge clk);
      snap();
      rx_if.rdy = 1'b1;
      align();
      send_bits(8'h5A, 1'b1);
      repeat (16) @(posedge clk);
      @(negedge clk);
      check("post_rst_acc_n", 32'(acc_n - b_acc), 32'd1);
      check("post_rst_data", 32'(acc_last), 32'h5A);
      check("post_rst_fe_n", 32'(fe_n - b_fe), 32'd0);
      check("post_rst_ov_n", 32'(ov_n - b_ov), 32'd0);
      check("post_rst_vld", 32'(rx_if.vld), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
